alu_exec_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_shift_unit.sv | 62 ++++++
 rtl/alu_exec_stage.sv | 149 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes from the ALU control decoder and
// the execute-stage state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_AND  = 4'd1;
  localparam logic [3:0] ALU_NOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SUB  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_OUT
  } state_e;

endpackage

// File: rtl/alu_shift_unit.sv
// Shift datapath for sll/srl.
// ALU_ITER_SHIFT_EN defined: shift register plus 5-bit down-counter, one bit
// per step; result_o is the value after the next single-bit step.
// ALU_ITER_SHIFT_EN undefined: purely combinational barrel shifter.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
`ifdef ALU_ITER_SHIFT_EN
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             step_i,
  output logic             last_o,
`endif
  input  logic             left_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [4:0]       shamt_i,
  output logic [WIDTH-1:0] result_o
);

`ifdef ALU_ITER_SHIFT_EN
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             left_q, left_d;

  // Load operand/amount on start, otherwise shift one bit per step.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    left_d = left_q;
    if (start_i) begin
      sreg_d = data_i;
      cnt_d  = shamt_i;
      left_d = left_i;
    end else if (step_i) begin
      sreg_d = result_o;
      cnt_d  = cnt_q - 5'd1;
    end
  end

  // Shift register, counter and direction state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      left_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      left_q <= left_d;
    end
  end

  assign result_o = left_q ? (sreg_q << 1) : (sreg_q >> 1);
  assign last_o   = (cnt_q == 5'd1);
`else
  assign result_o = left_i ? (data_i << shamt_i) : (data_i >> shamt_i);
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with valid/ready handshake on both sides and a
// registered result. Shift implementation selected by ALU_ITER_SHIFT_EN
// (defined: iterative multi-cycle, undefined: single-cycle barrel).
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [WIDTH-1:0] sum, diff, op_res, shift_res;
  logic             op_ovf;

  assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_OUT) && out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == ST_OUT);
  assign out_result = res_q;
  assign out_zero   = zero_q;
  assign out_ovf    = ovf_q;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

`ifdef ALU_ITER_SHIFT_EN
  logic is_shift, shift_last;
  assign is_shift = (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SRL);

  alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept && is_shift),
    .step_i   (state_q == ST_SHIFT),
    .last_o   (shift_last),
    .left_i   (alu_ctrl == ALU_SLL),
    .data_i   (op_b),
    .shamt_i  (shamt),
    .result_o (shift_res)
  );
`else
  alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
    .left_i   (alu_ctrl == ALU_SLL),
    .data_i   (op_b),
    .shamt_i  (shamt),
    .result_o (shift_res)
  );
`endif

  // Single-cycle operation result and signed overflow for the presented code.
  always_comb begin
    op_res = '0;
    op_ovf = 1'b0;
    case (alu_ctrl)
      ALU_ADD: begin
        op_res = sum;
        op_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        op_res = diff;
        op_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_AND:  op_res = op_a & op_b;
      ALU_OR:   op_res = op_a | op_b;
      ALU_NOR:  op_res = ~(op_a | op_b);
      ALU_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: op_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_ITER_SHIFT_EN
      // Only latched directly when shamt is zero; otherwise SHIFT produces it.
      ALU_SLL, ALU_SRL: op_res = op_b;
`else
      ALU_SLL, ALU_SRL: op_res = shift_res;
`endif
      default: op_res = '0;
    endcase
  end

  // Next state and result register update; an accept overrides the OUT drain.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_OUT: if (out_ready) state_d = ST_IDLE;
`ifdef ALU_ITER_SHIFT_EN
      ST_SHIFT: begin
        if (shift_last) begin
          state_d = ST_OUT;
          res_d   = shift_res;
          zero_d  = (shift_res == '0);
          ovf_d   = 1'b0;
        end
      end
`endif
      default: ;
    endcase
    if (accept) begin
`ifdef ALU_ITER_SHIFT_EN
      if (is_shift && (shamt != 5'd0)) begin
        state_d = ST_SHIFT;
      end else begin
        state_d = ST_OUT;
        res_d   = op_res;
        zero_d  = (op_res == '0);
        ovf_d   = op_ovf;
      end
`else
      state_d = ST_OUT;
      res_d   = op_res;
      zero_d  = (op_res == '0);
      ovf_d   = op_ovf;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage (works with or without ALU_ITER_SHIFT_EN).
module tb_alu_exec_stage;
  import alu_pkg::*;

`ifdef ALU_ITER_SHIFT_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_ovf;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        v;
  } exp_t;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    exp_t        e;
  } vec_t;

  exp_t sb[$];

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_ctrl   (alu_ctrl),
    .op_a       (op_a),
    .op_b       (op_b),
    .shamt      (shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Independent reference: wide signed arithmetic for overflow detection.
  function automatic exp_t model(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    exp_t   e;
    longint sa, sb_, wide;
    sa   = longint'($signed(a));
    sb_  = longint'($signed(b));
    e.v  = 1'b0;
    e.res = 32'h0;
    case (c)
      4'd0: begin wide = sa + sb_; e.res = wide[31:0]; e.v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      4'd8: begin wide = sa - sb_; e.res = wide[31:0]; e.v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      4'd1: e.res = a & b;
      4'd2: e.res = ~(a | b);
      4'd3: e.res = a | b;
      4'd4: e.res = (sa < sb_) ? 32'd1 : 32'd0;
      4'd5: e.res = ({32'h0, a} < {32'h0, b}) ? 32'd1 : 32'd0;
      4'd6: e.res = b << sh;
      4'd7: e.res = b >> sh;
      default: e.res = 32'h0;
    endcase
    e.z = (e.res == 32'h0);
    return e;
  endfunction

  // One clock: sample handshakes/outputs just before the edge, then advance.
  task automatic tick(output bit ti, output bit go, output exp_t obs);
    #1;
    ti  = in_valid && in_ready;
    go  = out_valid && out_ready;
    obs = {out_result, out_zero, out_ovf};
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    shamt    = sh;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({out_valid, out_result, out_zero, out_ovf, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset got v=%b r=%h z=%b o=%b rdy=%b exp v=0 r=0 z=0 o=0 rdy=1",
               out_valid, out_result, out_zero, out_ovf, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift();
    bit ti, go; exp_t obs;
    out_ready = 1'b0;
    drive(ALU_SLL, 32'h0, 32'h1, 5'd20);
    tick(ti, go, obs);
    in_valid = 1'b0;
    total++;
    if (ti !== 1'b1) begin bad++; $display("FAIL rst_mid_accept got %b exp 1", ti); end
    repeat (3) tick(ti, go, obs);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({out_valid, out_result, in_ready} !== {1'b0, 32'h0, 1'b1}) begin
      bad++;
      $display("FAIL rst_mid_shift got v=%b r=%h rdy=%b exp v=0 r=0 rdy=1", out_valid, out_result, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    vec_t v [10];
    bit ti, go; exp_t obs, e; int n = 0;
    v[0] = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0, {32'h80000000, 1'b0, 1'b1}};
    v[1] = '{ALU_SUB,  32'h00000005, 32'h00000005, 5'd0, {32'h00000000, 1'b1, 1'b0}};
    v[2] = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0, {32'h00000001, 1'b0, 1'b0}};
    v[3] = '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0, {32'h00000000, 1'b1, 1'b0}};
    v[4] = '{ALU_NOR,  32'h00000000, 32'h00000000, 5'd0, {32'hFFFFFFFF, 1'b0, 1'b0}};
    v[5] = '{4'd12,    32'h12345678, 32'h9ABCDEF0, 5'd3, {32'h00000000, 1'b1, 1'b0}};
    v[6] = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0, {32'hF000F000, 1'b0, 1'b0}};
    v[7] = '{ALU_OR,   32'hF0F0F0F0, 32'h0F000F00, 5'd0, {32'hFFF0FFF0, 1'b0, 1'b0}};
    v[8] = '{ALU_ADD,  32'h80000000, 32'h80000000, 5'd0, {32'h00000000, 1'b1, 1'b1}};
    v[9] = '{ALU_SUB,  32'h80000000, 32'h00000001, 5'd0, {32'h7FFFFFFF, 1'b0, 1'b1}};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i < 10) drive(v[i].c, v[i].a, v[i].b, v[i].sh);
      else in_valid = 1'b0;
      tick(ti, go, obs);
      if (ti) sb.push_back(v[i].e);
      if (go) begin
        total++;
        n++;
        if (sb.size() == 0) begin bad++; $display("FAIL arith unexpected result %h", obs.res); end
        else begin
          e = sb.pop_front();
          if (obs !== e) begin
            bad++;
            $display("FAIL arith[%0d] got r=%h z=%b o=%b exp r=%h z=%b o=%b",
                     n - 1, obs.res, obs.z, obs.v, e.res, e.z, e.v);
          end
        end
      end
    end
    total++;
    if (n != 10) begin bad++; $display("FAIL arith_count got %0d exp 10", n); end
  endtask

  task automatic test_shift();
    vec_t v [4];
    bit ti, go; exp_t obs, e; int lat, exp_lat;
    v[0] = '{ALU_SLL, 32'h0, 32'h00000001, 5'd31, {32'h80000000, 1'b0, 1'b0}};
    v[1] = '{ALU_SRL, 32'h0, 32'h80000000, 5'd0,  {32'h80000000, 1'b0, 1'b0}};
    v[2] = '{ALU_SRL, 32'h0, 32'hF0000000, 5'd4,  {32'h0F000000, 1'b0, 1'b0}};
    v[3] = '{ALU_SLL, 32'h0, 32'h000000FF, 5'd8,  {32'h0000FF00, 1'b0, 1'b0}};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(v[i].c, v[i].a, v[i].b, v[i].sh);
      tick(ti, go, obs);
      in_valid = 1'b0;
      if (ti) sb.push_back(v[i].e);
      lat = 1;
      while (!out_valid && lat < 40) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL shift_busy_ready[%0d] got %b exp 0", i, in_ready); end
        tick(ti, go, obs);
        lat++;
      end
      exp_lat = (ITER && v[i].sh != 5'd0) ? int'(v[i].sh) + 1 : 1;
      total++;
      if (lat != exp_lat) begin bad++; $display("FAIL shift_latency[%0d] got %0d exp %0d", i, lat, exp_lat); end
      tick(ti, go, obs);
      total++;
      if (!go || sb.size() == 0) begin
        bad++; $display("FAIL shift_out[%0d] got go=%b exp go=1", i, go);
        sb.delete();
      end else begin
        e = sb.pop_front();
        if (obs !== e) begin
          bad++;
          $display("FAIL shift[%0d] got r=%h z=%b o=%b exp r=%h z=%b o=%b", i, obs.res, obs.z, obs.v, e.res, e.z, e.v);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ti, go; exp_t obs, e;
    out_ready = 1'b0;
    drive(ALU_ADD, 32'd3, 32'd4, 5'd0);
    tick(ti, go, obs);
    in_valid = 1'b0;
    if (ti) sb.push_back({32'd7, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({out_valid, out_result, in_ready} !== {1'b1, 32'd7, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold[%0d] got v=%b r=%h rdy=%b exp v=1 r=7 rdy=0", i, out_valid, out_result, in_ready);
      end
      tick(ti, go, obs);
    end
    out_ready = 1'b1;
    drive(ALU_SUB, 32'd10, 32'd3, 5'd0);
    tick(ti, go, obs);
    in_valid = 1'b0;
    total++;
    if ({ti, go} !== 2'b11) begin bad++; $display("FAIL bp_same_cycle got in=%b out=%b exp 11", ti, go); end
    if (ti) sb.push_back({32'd7, 1'b0, 1'b0});
    for (int i = 0; i < 2; i++) begin
      if (i == 1) tick(ti, go, obs);
      if (go) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL bp unexpected result %h", obs.res); end
        else begin
          e = sb.pop_front();
          if (obs !== e) begin
            bad++;
            $display("FAIL bp[%0d] got r=%h z=%b o=%b exp r=%h z=%b o=%b", i, obs.res, obs.z, obs.v, e.res, e.z, e.v);
          end
        end
      end
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL bp_drain got %0d left exp 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_back_to_back();
    bit ti, go; exp_t obs, e;
    logic [3:0] c; logic [31:0] a, b; int r, outs = 0;
    out_ready = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      if (i < 100) begin
        r = int'($urandom_range(0, 12));
        c = (r < 6) ? 4'(r) : (r == 6) ? ALU_SUB : 4'(r + 2);
        a = $urandom;
        b = ($urandom_range(0, 7) == 0) ? a : $urandom;
        drive(c, a, b, 5'($urandom));
      end else in_valid = 1'b0;
      tick(ti, go, obs);
      if (i < 100) begin
        total++;
        if (!ti) begin bad++; $display("FAIL b2b_accept[%0d] got 0 exp 1", i); end
        else sb.push_back(model(c, a, b, shamt));
      end
      if (i > 0) begin
        total++;
        if (!go) begin bad++; $display("FAIL b2b_rate[%0d] got no result exp one", i); end
      end
      if (go) begin
        outs++;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL b2b unexpected result %h", obs.res); end
        else begin
          e = sb.pop_front();
          if (obs !== e) begin
            bad++;
            $display("FAIL b2b[%0d] got r=%h z=%b o=%b exp r=%h z=%b o=%b", outs - 1, obs.res, obs.z, obs.v, e.res, e.z, e.v);
          end
        end
      end
    end
    total++;
    if (outs != 100) begin bad++; $display("FAIL b2b_count got %0d exp 100", outs); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_shift();
    test_arith();
    test_shift();
    test_backpressure();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
